multicycle_main_fsm: RTL and testbench

//  Main control FSM for the multicycle ARM core. It sequences the shared ALU, memory port and register file

---
 rtl/multicycle_main_fsm.sv | 145 ++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle ARM core: sequences fetch, decode, execute,
// memory and writeback, with an optional memory-ready handshake.
module multicycle_main_fsm #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic               NoWrite,
    input  logic               CondEx,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        StFetch    = STATE_W'(0),
        StDecode   = STATE_W'(1),
        StMemAdr   = STATE_W'(2),
        StMemRead  = STATE_W'(3),
        StMemWb    = STATE_W'(4),
        StMemWrite = STATE_W'(5),
        StExecR    = STATE_W'(6),
        StExecI    = STATE_W'(7),
        StAluWb    = STATE_W'(8),
        StBranch   = STATE_W'(9)
    } state_e;

    state_e state_q, state_d, cur;
    logic   rdy;
    logic   pc_dest;
    logic   unused_funct;

    assign rdy          = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign pc_dest      = (Rd == 4'hF);
    assign unused_funct = ^Funct[4:1];
    assign state        = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StFetch;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:    state_d = rdy ? StDecode : StFetch;
            StDecode: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? StExecI : StExecR;
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = Funct[0] ? StMemRead : StMemWrite;
            StMemRead:  state_d = rdy ? StMemWb : StMemRead;
            StMemWrite: state_d = rdy ? StFetch : StMemWrite;
            StExecR,
            StExecI:    state_d = NoWrite ? StFetch : StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // Reset forces the FETCH select pattern and kills every strobe.
    always_comb begin
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUOp      = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        cur        = reset ? StFetch : state_q;
        case (cur)
            StFetch: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = rdy;
                PCWrite   = rdy;
            end
            StDecode: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (Op == 2'b11) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            StMemAdr:   ALUSrcB = 2'b01;
            StMemRead:  AdrSrc = 1'b1;
            StMemWrite: begin
                AdrSrc     = 1'b1;
                MemWrite   = CondEx & rdy;
                instr_done = rdy;
            end
            StMemWb, StAluWb: begin
                ResultSrc  = (cur == StMemWb) ? 2'b01 : 2'b00;
                RegWrite   = CondEx & ~pc_dest;
                PCWrite    = CondEx & pc_dest;
                instr_done = 1'b1;
            end
            StExecR, StExecI: begin
                ALUSrcB    = (cur == StExecI) ? 2'b01 : 2'b00;
                ALUOp      = 1'b1;
                instr_done = NoWrite;
            end
            StBranch: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                PCWrite    = CondEx;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Cycle-by-cycle vector table for the multicycle main FSM; each row's expected state and
// outputs go through a scoreboard queue and are compared mid-cycle.
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic       NoWrite = 1'b0;
    logic       CondEx = 1'b0;
    logic       mem_ready = 1'b0;
    logic       IRWrite, AdrSrc, ALUOp, PCWrite, RegWrite, MemWrite, instr_done, illegal_op;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] state;

    multicycle_main_fsm #(.MEM_HANDSHAKE(1'b1), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .NoWrite(NoWrite),
        .CondEx(CondEx), .mem_ready(mem_ready), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .instr_done(instr_done),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic        nw;
        logic        ce;
        logic        rdy;
        logic [3:0]  st;
        logic [13:0] outs;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  st;
        logic [13:0] outs;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mw_pulses = 0;

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, PCWrite, RegWrite, MemWrite,
    //  instr_done, illegal_op}
    function automatic logic [13:0] o(input logic ir, input logic adr, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] r,
                                      input logic aop, input logic pcw, input logic rw,
                                      input logic mw, input logic done, input logic ill);
        return {ir, adr, a, b, r, aop, pcw, rw, mw, done, ill};
    endfunction

    task automatic v(input logic rst, input logic [1:0] op, input logic [5:0] funct,
                     input logic [3:0] rd, input logic nw, input logic ce, input logic rdy,
                     input logic [3:0] st, input logic [13:0] outs);
        vec_t t;
        t.rst = rst; t.op = op; t.funct = funct; t.rd = rd; t.nw = nw; t.ce = ce;
        t.rdy = rdy; t.st = st; t.outs = outs;
        vecs.push_back(t);
    endtask

    always @(negedge clk) begin
        if (MemWrite === 1'b1) mw_pulses++;
        if (sb.size() != 0) begin
            exp_t e;
            logic [13:0] act;
            e = sb.pop_front();
            act = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, PCWrite, RegWrite,
                   MemWrite, instr_done, illegal_op};
            checks++;
            if (state !== e.st || act !== e.outs) begin
                errors++;
                $display("FAIL vec%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                         e.idx, state, act, e.st, e.outs);
            end
        end
    end

    initial begin
        logic [13:0] f_idle, f_go, dec;
        f_idle = o(0, 0, 2'd1, 2'd2, 2'd2, 0, 0, 0, 0, 0, 0);
        f_go   = o(1, 0, 2'd1, 2'd2, 2'd2, 0, 1, 0, 0, 0, 0);
        dec    = f_idle;

        // Reset, then LDR interrupted by a 2-cycle reset while stalled in MEMREAD
        v(1, 2'b01, 6'b000001, 4'd2, 0, 1, 1, 4'd0, f_idle);
        v(0, 2'b01, 6'b000001, 4'd2, 0, 1, 1, 4'd0, f_go);
        v(0, 2'b01, 6'b000001, 4'd2, 0, 1, 1, 4'd1, dec);
        v(0, 2'b01, 6'b000001, 4'd2, 0, 1, 1, 4'd2, o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        v(0, 2'b01, 6'b000001, 4'd2, 0, 1, 0, 4'd3, o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v(1, 2'b01, 6'b000001, 4'd2, 0, 1, 1, 4'd3, f_idle);
        v(1, 2'b01, 6'b000001, 4'd2, 0, 1, 1, 4'd0, f_idle);
        // ADD reg, Rd=1
        v(0, 2'b00, 6'b001000, 4'd1, 0, 1, 1, 4'd0, f_go);
        v(0, 2'b00, 6'b001000, 4'd1, 0, 1, 1, 4'd1, dec);
        v(0, 2'b00, 6'b001000, 4'd1, 0, 1, 1, 4'd6, o(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        v(0, 2'b00, 6'b001000, 4'd1, 0, 1, 1, 4'd8, o(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        // CMP imm
        v(0, 2'b00, 6'b110101, 4'd0, 1, 1, 1, 4'd0, f_go);
        v(0, 2'b00, 6'b110101, 4'd0, 1, 1, 1, 4'd1, dec);
        v(0, 2'b00, 6'b110101, 4'd0, 1, 1, 1, 4'd7, o(0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
        // LDR with 3 wait cycles in MEMREAD
        v(0, 2'b01, 6'b000001, 4'd2, 0, 1, 1, 4'd0, f_go);
        v(0, 2'b01, 6'b000001, 4'd2, 0, 1, 1, 4'd1, dec);
        v(0, 2'b01, 6'b000001, 4'd2, 0, 1, 1, 4'd2, o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            v(0, 2'b01, 6'b000001, 4'd2, 0, 1, 0, 4'd3, o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 2'b01, 6'b000001, 4'd2, 0, 1, 1, 4'd3, o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 2'b01, 6'b000001, 4'd2, 0, 1, 1, 4'd4, o(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0));
        // STR with CondEx=0
        v(0, 2'b01, 6'b000000, 4'd3, 0, 0, 1, 4'd0, f_go);
        v(0, 2'b01, 6'b000000, 4'd3, 0, 0, 1, 4'd1, dec);
        v(0, 2'b01, 6'b000000, 4'd3, 0, 0, 1, 4'd2, o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        v(0, 2'b01, 6'b000000, 4'd3, 0, 0, 1, 4'd5, o(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // STR with CondEx=1 and one wait cycle
        v(0, 2'b01, 6'b000000, 4'd3, 0, 1, 1, 4'd0, f_go);
        v(0, 2'b01, 6'b000000, 4'd3, 0, 1, 1, 4'd1, dec);
        v(0, 2'b01, 6'b000000, 4'd3, 0, 1, 1, 4'd2, o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        v(0, 2'b01, 6'b000000, 4'd3, 0, 1, 0, 4'd5, o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 2'b01, 6'b000000, 4'd3, 0, 1, 1, 4'd5, o(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        // B, with a stalled fetch first
        v(0, 2'b10, 6'b000000, 4'd0, 0, 1, 0, 4'd0, f_idle);
        v(0, 2'b10, 6'b000000, 4'd0, 0, 1, 1, 4'd0, f_go);
        v(0, 2'b10, 6'b000000, 4'd0, 0, 1, 1, 4'd1, dec);
        v(0, 2'b10, 6'b000000, 4'd0, 0, 1, 1, 4'd9, o(0, 0, 0, 1, 2, 0, 1, 0, 0, 1, 0));
        // Illegal Op=11
        v(0, 2'b11, 6'b000000, 4'd0, 0, 1, 1, 4'd0, f_go);
        v(0, 2'b11, 6'b000000, 4'd0, 0, 1, 1, 4'd1, o(0, 0, 1, 2, 2, 0, 0, 0, 0, 1, 1));
        // ADD to Rd=15 writes the PC instead of the register file
        v(0, 2'b00, 6'b001000, 4'hF, 0, 1, 1, 4'd0, f_go);
        v(0, 2'b00, 6'b001000, 4'hF, 0, 1, 1, 4'd1, dec);
        v(0, 2'b00, 6'b001000, 4'hF, 0, 1, 1, 4'd6, o(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        v(0, 2'b00, 6'b001000, 4'hF, 0, 1, 1, 4'd8, o(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        // Failed condition still walks to ALUWB but writes nothing
        v(0, 2'b00, 6'b001000, 4'hF, 0, 0, 1, 4'd0, f_go);
        v(0, 2'b00, 6'b001000, 4'hF, 0, 0, 1, 4'd1, dec);
        v(0, 2'b00, 6'b001000, 4'hF, 0, 0, 1, 4'd6, o(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        v(0, 2'b00, 6'b001000, 4'hF, 0, 0, 1, 4'd8, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        v(0, 2'b00, 6'b001000, 4'd0, 0, 0, 1, 4'd0, f_go);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            reset = vecs[i].rst; Op = vecs[i].op; Funct = vecs[i].funct; Rd = vecs[i].rd;
            NoWrite = vecs[i].nw; CondEx = vecs[i].ce; mem_ready = vecs[i].rdy;
            e.idx = i; e.st = vecs[i].st; e.outs = vecs[i].outs;
            sb.push_back(e);
        end

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        // Exactly one store in the whole run had CondEx=1
        checks++;
        if (mw_pulses != 1) begin
            errors++;
            $display("FAIL memwrite_pulses: got %0d, expected 1", mw_pulses);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
